// File: rtl/logic_fifo_read_stream_pkg.sv
// logic_fifo_read_stream_pkg
// Shared sizing helpers for the FIFO-read-to-stream adapter.
//   depth(read_latency)  : prefetch buffer entries needed to cover the read latency
//   count_width(depth)   : bits needed to hold an occupancy value 0..depth
// Also provides the LOGIC_DRC elaboration-time parameter check macro.

`ifndef LOGIC_DRC
`define LOGIC_DRC(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end
`endif

package logic_fifo_read_stream_pkg;

    // One entry per read in flight, one for the word being presented,
    // and one so a request can be issued in the cycle of a pop.
    function automatic int depth(input int read_latency);
        return read_latency + 2;
    endfunction

    function automatic int count_width(input int entries);
        return $clog2(entries + 1);
    endfunction

endpackage

// File: rtl/logic_fifo_read_stream_buffer.sv
// logic_fifo_read_stream_buffer
// DEPTH x WIDTH circular prefetch buffer with a combinational head read.
// Ports:
//   clk, srst           : clock, synchronous active-high reset (pointers/count only)
//   push, push_data     : write push_data at the tail
//   pop                 : retire the head entry
//   head_data           : current head entry
//   count, full, empty  : occupancy status

module logic_fifo_read_stream_buffer
    import logic_fifo_read_stream_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3,
    localparam int CW   = count_width(DEPTH),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;

    // DEPTH is generally not a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage carries no reset; stale contents are never exposed because
    // count gates tx_tvalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem[head_reg];
    assign count     = count_reg;
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);

    // The credit rule upstream must make these impossible.
    overflow_check: assert property (@(posedge clk) disable iff (srst)
        !(push && full && !pop));
    underflow_check: assert property (@(posedge clk) disable iff (srst)
        !(pop && empty));

endmodule

// File: rtl/logic_fifo_read_stream.sv
// logic_fifo_read_stream
// Drains a non-show-ahead FIFO read port (fixed READ_LATENCY) into an
// AXI4-Stream transmitter at one word per cycle. Reads are issued on credit:
// a request is made only when the buffer is guaranteed room for the returning word.
// Ports:
//   aclk, reset       : clock, synchronous active-high reset
//   fifo_empty        : source FIFO has no words
//   fifo_read_enable  : read request to the source FIFO
//   fifo_read_data    : source data, valid READ_LATENCY cycles after a request
//   tx_tvalid/tready  : stream handshake
//   tx_tdata          : stream data (buffer head)

module logic_fifo_read_stream
    import logic_fifo_read_stream_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int READ_LATENCY = 1,
    localparam int DEPTH       = depth(READ_LATENCY),
    localparam int CW          = count_width(DEPTH)
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic             fifo_empty,
    output logic             fifo_read_enable,
    input  logic [WIDTH-1:0] fifo_read_data,
    output logic             tx_tvalid,
    input  logic             tx_tready,
    output logic [WIDTH-1:0] tx_tdata
);

    `LOGIC_DRC(g_drc_read_latency, (READ_LATENCY >= 1) && (READ_LATENCY <= 4),
               "logic_fifo_read_stream: READ_LATENCY must be 1..4")
    `LOGIC_DRC(g_drc_width, (WIDTH >= 1),
               "logic_fifo_read_stream: WIDTH must be >= 1")

    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic                    run_reg;
    logic [READ_LATENCY-1:0] vld_reg;
    logic [CW-1:0]           inflight_reg;
    logic [CW-1:0]           inflight_next;
    logic [CW-1:0]           count;
    logic [CW:0]             committed;
    logic                    buf_full;
    logic                    buf_empty;
    logic                    data_return;
    logic                    pop;

    // Holds requests off in the first cycle after reset release.
    always_ff @(posedge aclk) begin
        if (reset) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // Words held plus words still on their way must fit in the buffer.
    assign committed        = {1'b0, count} + {1'b0, inflight_reg};
    assign fifo_read_enable = !reset && run_reg && !fifo_empty && (committed < DEPTH_W);

    // Valid pipeline mirrors the FIFO read latency; the last stage marks
    // fifo_read_data as a real word.
    always_ff @(posedge aclk) begin
        if (reset) begin
            vld_reg <= '0;
        end else begin
            vld_reg[0] <= fifo_read_enable;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
        end
    end

    assign data_return = vld_reg[READ_LATENCY-1];

    always_comb begin
        inflight_next = inflight_reg;
        case ({fifo_read_enable, data_return})
            2'b10:   inflight_next = inflight_reg + CW'(1);
            2'b01:   inflight_next = inflight_reg - CW'(1);
            default: inflight_next = inflight_reg;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    assign tx_tvalid = !buf_empty;
    assign pop       = tx_tvalid && tx_tready;

    logic_fifo_read_stream_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (aclk),
        .srst      (reset),
        .push      (data_return),
        .push_data (fifo_read_data),
        .pop       (pop),
        .head_data (tx_tdata),
        .count     (count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // A full buffer leaves no credit, so no request may be issued.
    no_request_when_full: assert property (@(posedge aclk) disable iff (reset)
        buf_full |-> !fifo_read_enable);

endmodule

// File: tb/tb_logic_fifo_read_stream.sv
// Testbench for logic_fifo_read_stream: one DUT per READ_LATENCY 1..4, each
// with its own source FIFO model, scoreboard and directed scenario list.

module tb_logic_fifo_read_stream;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source words are numbered from 0; word k carries value 0x10 + k.
    function automatic logic [W-1:0] word(input int k);
        return W'(k + 16);
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_lat
        localparam int RL = gi + 1;
        localparam int D  = RL + 2;

        logic         reset;
        logic         tready;
        logic         hold_empty;
        logic         fifo_empty;
        logic         rd_en;
        logic         tvalid;
        logic [W-1:0] rd_data;
        logic [W-1:0] tdata;
        logic         done = 1'b0;

        int           src_limit = 0;
        int           src_next  = 0;
        logic [W-1:0] dl [RL];
        logic [W-1:0] exp_q [$];
        logic [W-1:0] exp_w;
        logic         prev_v   = 1'b0;
        logic         prev_r   = 1'b0;
        logic         prev_rst = 1'b1;
        logic [W-1:0] prev_d   = '0;

        logic_fifo_read_stream #(
            .WIDTH        (W),
            .READ_LATENCY (RL)
        ) dut (
            .aclk             (clk),
            .reset            (reset),
            .fifo_empty       (fifo_empty),
            .fifo_read_enable (rd_en),
            .fifo_read_data   (rd_data),
            .tx_tvalid        (tvalid),
            .tx_tready        (tready),
            .tx_tdata         (tdata)
        );

        // Source FIFO model: fixed-latency read port, reset together with the DUT.
        assign fifo_empty = hold_empty || (src_next >= src_limit);
        assign rd_data    = dl[RL-1];

        always @(posedge clk) begin
            if (reset) begin
                exp_q.delete();
            end else if (rd_en) begin
                exp_q.push_back(word(src_next));
            end
            if (rd_en) begin
                src_next <= src_next + 1;
            end
            dl[0] <= word(src_next);
            for (int k = 1; k < RL; k++) begin
                dl[k] <= dl[k-1];
            end
        end

        task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
            check($sformatf("L%0d %s", RL, tag), got, exp);
        endtask

        // Scoreboard and AXI stability monitor, sampled mid-cycle.
        always @(negedge clk) begin
            if (tvalid && tready) begin
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                end else begin
                    exp_w = 16'hDEAD;
                end
                chk("sb data", 32'(tdata), 32'(exp_w));
            end
            if (prev_v && !prev_r && !prev_rst && !reset) begin
                chk("axi tvalid hold", 32'(tvalid), 32'd1);
                chk("axi tdata hold", 32'(tdata), 32'(prev_d));
            end
            prev_v   = tvalid;
            prev_r   = tready;
            prev_rst = reset;
            prev_d   = tdata;
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic smp();
            @(negedge clk);
        endtask

        initial begin : run
            int base;
            int n;
            int gaps;
            int reqs;
            bit seen;

            // Reset / idle
            reset      = 1'b1;
            tready     = 1'b0;
            hold_empty = 1'b0;
            src_limit  = 32'h4000_0000;
            for (int i = 0; i < 3; i++) begin
                smp();
                chk("reset rd_en", 32'(rd_en), 32'd0);
                chk("reset tvalid", 32'(tvalid), 32'd0);
                tick();
            end
            reset = 1'b0;
            smp();
            chk("release rd_en", 32'(rd_en), 32'd0);
            chk("release tvalid", 32'(tvalid), 32'd0);
            tick();
            smp();
            chk("first request", 32'(rd_en), 32'd1);
            tick();
            hold_empty = 1'b1;
            tready     = 1'b1;
            repeat (RL + 6) tick();

            // First-word latency: word 1 (value 0x11)
            smp();
            chk("idle tvalid", 32'(tvalid), 32'd0);
            tick();
            hold_empty = 1'b0;
            smp();
            chk("lat request", 32'(rd_en), 32'd1);
            tick();
            hold_empty = 1'b1;
            for (int c = 1; c <= RL; c++) begin
                smp();
                chk("lat early tvalid", 32'(tvalid), 32'd0);
                tick();
            end
            smp();
            chk("lat tvalid", 32'(tvalid), 32'd1);
            chk("lat tdata", 32'(tdata), 32'h0011);
            tick();
            repeat (4) tick();

            // Streaming: 100 words back to back
            src_limit  = src_next + 100;
            hold_empty = 1'b0;
            tready     = 1'b1;
            n    = 0;
            gaps = 0;
            seen = 1'b0;
            for (int c = 0; c < 400 && n < 100; c++) begin
                smp();
                if (tvalid) begin
                    n++;
                    seen = 1'b1;
                end else if (seen) begin
                    gaps++;
                end
                tick();
            end
            chk("stream count", 32'(n), 32'd100);
            chk("stream gaps", 32'(gaps), 32'd0);
            hold_empty = 1'b1;
            repeat (RL + 4) tick();

            // Backpressure: only D requests, then restart after first pop
            tready     = 1'b0;
            src_limit  = 32'h4000_0000;
            hold_empty = 1'b0;
            base       = src_next;
            reqs       = 0;
            for (int c = 0; c < 20; c++) begin
                smp();
                if (rd_en) reqs++;
                tick();
            end
            smp();
            chk("bp requests", 32'(reqs), 32'(D));
            chk("bp tvalid", 32'(tvalid), 32'd1);
            chk("bp head", 32'(tdata), 32'(word(base)));
            tick();
            tready = 1'b1;
            smp();
            chk("bp pop0 tvalid", 32'(tvalid), 32'd1);
            chk("bp pop0 rd_en", 32'(rd_en), 32'd0);
            tick();
            smp();
            chk("bp pop1 tvalid", 32'(tvalid), 32'd1);
            chk("bp resume rd_en", 32'(rd_en), 32'd1);
            tick();
            smp();
            chk("bp pop2 tvalid", 32'(tvalid), 32'd1);
            tick();
            hold_empty = 1'b1;
            repeat (RL + 6) tick();

            // Random source/sink patterns
            for (int c = 0; c < 250; c++) begin
                hold_empty = ($urandom_range(0, 3) == 0);
                tready     = ($urandom_range(0, 2) != 0);
                tick();
            end
            hold_empty = 1'b1;
            tready     = 1'b1;
            repeat (RL + 8) tick();
            smp();
            chk("rand drained tvalid", 32'(tvalid), 32'd0);
            chk("rand leftover words", 32'(exp_q.size()), 32'd0);
            tick();

            // Reset while reads are in flight
            tready     = 1'b0;
            hold_empty = 1'b0;
            base       = src_next;
            tick();
            tick();
            hold_empty = 1'b1;
            reset      = 1'b1;
            tick();
            tick();
            reset = 1'b0;
            for (int c = 0; c < RL + 3; c++) begin
                smp();
                chk("mid reset tvalid", 32'(tvalid), 32'd0);
                tick();
            end
            hold_empty = 1'b0;
            smp();
            chk("mid fresh request", 32'(rd_en), 32'd1);
            tick();
            hold_empty = 1'b1;
            for (int c = 1; c <= RL; c++) begin
                smp();
                chk("mid early tvalid", 32'(tvalid), 32'd0);
                tick();
            end
            smp();
            chk("mid fresh tvalid", 32'(tvalid), 32'd1);
            chk("mid fresh tdata", 32'(tdata), 32'(word(base + 2)));
            tick();
            tready = 1'b1;
            repeat (RL + 4) tick();
            smp();
            chk("mid drained", 32'(exp_q.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin : summary
        int c;
        logic all_done;
        c        = 0;
        all_done = 1'b0;
        while (!all_done && c < 20000) begin
            @(posedge clk);
            c++;
            all_done = g_lat[0].done && g_lat[1].done && g_lat[2].done && g_lat[3].done;
        end
        check("scenarios finished", 32'(all_done), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
